// File: rtl/axi_regbank_pkg.sv
// axi_regbank_pkg: shared constants and helpers for the AXI4-Lite register bank.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_e / rd_state_e : write and read channel FSM states
//   word_index()            : byte address -> register word index
package axi_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  // Drops the byte-lane bits; only 32- and 64-bit data widths are supported.
  function automatic logic [31:0] word_index(input logic [63:0] addr, input int unsigned data_w);
    return (data_w == 64) ? 32'(addr >> 3) : 32'(addr >> 2);
  endfunction

endpackage

// File: rtl/axi_regbank_strb_reg.sv
// axi_regbank_strb_reg: one DATA_W register with per-byte write enables.
//   i_clk / i_rst_n : clock, async active-low reset (clears to 0)
//   i_we            : write enable for this register
//   i_strb          : byte lanes to update when i_we is high
//   i_wdata         : write data
//   o_q             : current register value
module axi_regbank_strb_reg #(
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_strb,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_strb[b]) r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: parametrised AXI4-Lite slave register bank.
//   ACLK / ARESETN      : clock, async active-low reset
//   S_AXI_AW*/W*/B*     : write address/data/response channels (AWPROT ignored)
//   S_AXI_AR*/R*        : read address/data channels (ARPROT ignored)
//   reg_o               : flattened RW register contents, reg i at [i*DATA_W +: DATA_W]
//   status_i            : flattened status inputs, read through RO_MASK registers
//   wr_pulse_o          : one-cycle strobe per register, the cycle after a write lands
// Build option: define AXI_REGBANK_SLVERR_EN to answer out-of-range accesses
// and writes to read-only registers with SLVERR instead of OKAY.
module axi_lite_regbank
  import axi_regbank_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 6,
  parameter int                  NUM_REGS = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_o,
  input  logic [NUM_REGS*DATA_W-1:0] status_i,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  wr_state_e r_wstate, w_wstate_nxt;
  rd_state_e r_rstate, w_rstate_nxt;

  logic                             r_awready, r_arready;
  logic [1:0]                       r_bresp, r_rresp;
  logic [NUM_REGS-1:0]              r_wr_pulse;
  logic [DATA_W-1:0]                r_rdata;
  logic [31:0]                      w_widx, w_ridx;
  logic [NUM_REGS-1:0]              w_wsel;
  logic                             w_wr_hs, w_rd_hs, w_wr_ok, w_rd_ok;
  logic [1:0]                       w_wresp, w_rresp;
  logic [DATA_W-1:0]                w_rd_val;
  logic [NUM_REGS-1:0][DATA_W-1:0]  w_regs, w_rd_word;
  logic                             w_unused;

  // Protection bits and RW-slice status bits carry no meaning here.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_i};

  assign w_widx  = word_index(64'(S_AXI_AWADDR), DATA_W);
  assign w_ridx  = word_index(64'(S_AXI_ARADDR), DATA_W);
  // AW and W are only ever taken together, so one ready drives both.
  assign w_wr_hs = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_hs = r_arready & S_AXI_ARVALID;
  assign w_wr_ok = |w_wsel;
  assign w_rd_ok = (w_ridx < NUM_REGS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
        assign w_wsel[gi]    = 1'b0;
        assign w_regs[gi]    = '0;
        assign w_rd_word[gi] = status_i[gi*DATA_W +: DATA_W];
      end else begin : g_rw
        assign w_wsel[gi] = (w_widx == gi);
        axi_regbank_strb_reg #(.DATA_W(DATA_W)) u_reg (
          .i_clk   (ACLK),
          .i_rst_n (ARESETN),
          .i_we    (w_wr_hs & w_wsel[gi]),
          .i_strb  (S_AXI_WSTRB),
          .i_wdata (S_AXI_WDATA),
          .o_q     (w_regs[gi])
        );
        assign w_rd_word[gi] = w_regs[gi];
      end
    end
  endgenerate

  // Reads sample the pre-edge register values, so a same-cycle write is not seen.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ridx == i) w_rd_val = w_rd_word[i];
    end
  end

  always_comb begin
`ifdef AXI_REGBANK_SLVERR_EN
    w_wresp = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    w_rresp = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
`else
    w_wresp = RESP_OKAY;
    w_rresp = RESP_OKAY;
`endif
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_hs) w_wstate_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_rd_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      // Ready is a single-cycle pulse; the !r_awready term stops a re-arm on the handshake edge.
      r_awready  <= (r_wstate == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID && !r_awready;
      r_wr_pulse <= w_wr_hs ? w_wsel : '0;
      if (w_wr_hs) r_bresp <= w_wresp;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (r_rstate == R_IDLE) && S_AXI_ARVALID && !r_arready;
      if (w_rd_hs) begin
        r_rdata <= w_rd_ok ? w_rd_val : '0;
        r_rresp <= w_rresp;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_o         = w_regs;
  assign wr_pulse_o    = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_regbank.sv
module tb_axi_lite_regbank;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [5:0]   AWADDR, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;
  logic [127:0] reg_o, status_i;
  logic [3:0]   wr_pulse_o;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_regbank #(.DATA_W(32), .ADDR_W(6), .NUM_REGS(4), .RO_MASK(4'b0100)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .reg_o(reg_o), .status_i(status_i), .wr_pulse_o(wr_pulse_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one write; with hold=1 it leaves BVALID pending for the caller.
  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output logic [1:0] resp, output logic [3:0] pulse);
    int n;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; n = 0;
    @(posedge ACLK); #1;
    while (!AWREADY && n < 20) begin @(posedge ACLK); #1; n++; end
    chk("awready_latency", 128'(n), 128'd0);
    chk("wready_with_awready", {127'd0, WREADY}, 128'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("bvalid", {127'd0, BVALID}, 128'd1);
    resp = BRESP; pulse = wr_pulse_o;
    if (!hold) begin
      BREADY = 1'b1; @(posedge ACLK); #1; BREADY = 1'b0;
      chk("bvalid_clear", {127'd0, BVALID}, 128'd0);
      chk("pulse_one_cycle", {124'd0, wr_pulse_o}, 128'd0);
    end
  endtask

  task automatic axi_rd(input logic [5:0] a, input bit hold,
                        output logic [31:0] d, output logic [1:0] resp);
    int n;
    ARADDR = a; ARVALID = 1'b1; n = 0;
    @(posedge ACLK); #1;
    while (!ARREADY && n < 20) begin @(posedge ACLK); #1; n++; end
    chk("arready_latency", 128'(n), 128'd0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    chk("rvalid", {127'd0, RVALID}, 128'd1);
    d = RDATA; resp = RRESP;
    if (!hold) begin
      RREADY = 1'b1; @(posedge ACLK); #1; RREADY = 1'b0;
      chk("rvalid_clear", {127'd0, RVALID}, 128'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] d;
    int bad_v, bad_rdy, bad_d;

    ARESETN = 1'b0; AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    WDATA = '0; WSTRB = '0;
    status_i = {32'h0, 32'hDEADBEEF, 32'h0, 32'hCAFEF00D};
    repeat (2) @(posedge ACLK);
    #1;
    chk("reset_reg_o", reg_o, 128'd0);
    chk("reset_valid_ready", {124'd0, BVALID, RVALID, AWREADY, ARREADY}, 128'd0);
    chk("reset_pulse", {124'd0, wr_pulse_o}, 128'd0);
    chk("reset_rdata", {96'd0, RDATA}, 128'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Basic writes; register 2 is read-only and must ignore its write.
    for (int i = 0; i < 4; i++) begin
      axi_wr(6'(i*4), 32'(i+1), 4'hF, 1'b0, resp, pulse);
      chk($sformatf("wr%0d_resp", i), {126'd0, resp}, 128'd0);
      chk($sformatf("wr%0d_pulse", i), {124'd0, pulse}, (i == 2) ? 128'd0 : 128'(1 << i));
    end
    chk("reg_o_after_writes", reg_o, 128'h00000004_00000000_00000002_00000001);
    for (int i = 0; i < 4; i++) begin
      axi_rd(6'(i*4), 1'b0, d, resp);
      chk($sformatf("rd%0d_data", i), {96'd0, d}, (i == 2) ? 128'hDEADBEEF : 128'(i+1));
      chk($sformatf("rd%0d_resp", i), {126'd0, resp}, 128'd0);
    end

    // Out-of-range accesses: zero data, OKAY, no state change.
    axi_rd(6'h10, 1'b0, d, resp);
    chk("oor_rd_data", {96'd0, d}, 128'd0);
    chk("oor_rd_resp", {126'd0, resp}, 128'd0);
    axi_wr(6'h14, 32'hFFFFFFFF, 4'hF, 1'b0, resp, pulse);
    chk("oor_wr_pulse", {124'd0, pulse}, 128'd0);
    chk("oor_wr_resp", {126'd0, resp}, 128'd0);
    chk("oor_wr_reg_o", reg_o, 128'h00000004_00000000_00000002_00000001);

    // Write response stalled 10 cycles while another AW/W waits.
    axi_wr(6'h0, 32'h11223344, 4'hF, 1'b1, resp, pulse);
    AWADDR = 6'h4; WDATA = 32'h99; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    bad_v = 0; bad_rdy = 0;
    repeat (10) begin
      @(posedge ACLK); #1;
      if (BVALID !== 1'b1 || BRESP !== 2'b00) bad_v++;
      if (AWREADY !== 1'b0 || WREADY !== 1'b0) bad_rdy++;
    end
    chk("bstall_bvalid_stable", 128'(bad_v), 128'd0);
    chk("bstall_no_accept", 128'(bad_rdy), 128'd0);
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    @(posedge ACLK); #1; BREADY = 1'b0;
    chk("bstall_release", {127'd0, BVALID}, 128'd0);
    chk("bstall_reg_o", reg_o, 128'h00000004_00000000_00000002_11223344);

    // Partial strobe: only byte 1 of reg 0 changes.
    axi_wr(6'h0, 32'hAABBCCDD, 4'b0010, 1'b0, resp, pulse);
    chk("strb_pulse", {124'd0, pulse}, 128'd1);
    axi_rd(6'h0, 1'b0, d, resp);
    chk("strb_rdata", {96'd0, d}, 128'h1122CC44);

    // Read response stalled 10 cycles while another AR waits.
    axi_rd(6'h0, 1'b1, d, resp);
    ARADDR = 6'h4; ARVALID = 1'b1;
    bad_v = 0; bad_rdy = 0; bad_d = 0;
    repeat (10) begin
      @(posedge ACLK); #1;
      if (RVALID !== 1'b1) bad_v++;
      if (ARREADY !== 1'b0) bad_rdy++;
      if (RDATA !== 32'h1122CC44) bad_d++;
    end
    chk("rstall_rvalid_stable", 128'(bad_v), 128'd0);
    chk("rstall_no_accept", 128'(bad_rdy), 128'd0);
    chk("rstall_rdata_stable", 128'(bad_d), 128'd0);
    ARVALID = 1'b0; RREADY = 1'b1;
    @(posedge ACLK); #1; RREADY = 1'b0;
    chk("rstall_release", {127'd0, RVALID}, 128'd0);

    // Reset while a write response and its pulse are pending.
    axi_wr(6'h4, 32'h55, 4'hF, 1'b1, resp, pulse);
    chk("pre_reset_pulse", {124'd0, pulse}, 128'd2);
    #2 ARESETN = 1'b0;
    #1;
    chk("async_rst_bvalid", {127'd0, BVALID}, 128'd0);
    chk("async_rst_pulse", {124'd0, wr_pulse_o}, 128'd0);
    chk("async_rst_reg_o", reg_o, 128'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk("post_rst_no_stale_b", {127'd0, BVALID}, 128'd0);
    axi_rd(6'h0, 1'b0, d, resp);
    chk("post_rst_rd0", {96'd0, d}, 128'd0);
    chk("post_rst_no_stale_b2", {127'd0, BVALID}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
# axi_lite_regbank

Parametrised AXI4-Lite slave register bank: the next-generation replacement for the fixed four-register AXI-Lite slave in our custom IP cores. It provides NUM_REGS registers of DATA_W bits, byte-strobe writes, per-register read-only/status mapping and one-cycle write pulses to user logic. It sits between the AXI interconnect (driven by the master VIP in benches) and the core's control/status logic.

## Interface
- DATA_W, 32, AXI data width; 32 or 64 only
- ADDR_W, 6, AXI address width; must satisfy 2^ADDR_W >= NUM_REGS*DATA_W/8
- NUM_REGS, 4, number of registers; 1..64
- RO_MASK, 0, NUM_REGS-bit mask; bit i = 1 makes register i read-only (reads status_i slice i)
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel; AWPROT ignored
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  ADDR_W/3/1/1  read address; ARPROT ignored
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  DATA_W/2/1/1  read data
- reg_o  out  NUM_REGS*DATA_W  flattened RW register contents, reg i at [i*DATA_W +: DATA_W]
- status_i  in  NUM_REGS*DATA_W  flattened status values, used only for RO_MASK slices
- wr_pulse_o  out  NUM_REGS  one-cycle strobe, bit i high in the cycle after register i is written

## Operation
- Word index = ADDR[ADDR_W-1 : log2(DATA_W/8)]; low address bits ignored. Index >= NUM_REGS is out of range.
- Write FSM: W_IDLE -> W_RESP. In W_IDLE, AWREADY and WREADY are asserted together for exactly one cycle when AWVALID && WVALID are both high; AW and W are never accepted separately. At that handshake edge each byte b of the target register with WSTRB[b] = 1 is updated. W_RESP holds BVALID until BREADY, then returns to W_IDLE.
- Writes to RO registers or out-of-range indices leave all state unchanged; wr_pulse_o does not fire.
- Read FSM: R_IDLE -> R_DATA. ARREADY is a one-cycle pulse in R_IDLE when ARVALID is high. RDATA is captured at that edge (RW: register value; RO: status_i slice; out of range: 0). R_DATA holds RVALID and RDATA stable until RREADY.
- The read and write FSMs are independent. Each supports one outstanding transaction.
- Simultaneous read and write of the same register in the same cycle: the read returns the pre-write value.
- BRESP/RRESP = OKAY (2'b00) except as modified by the configuration macro.
- Reset: all registers, reg_o, wr_pulse_o, BVALID, RVALID, AWREADY, WREADY, ARREADY, RDATA, BRESP and RRESP go to 0 immediately. Both FSMs return to idle. An in-flight transaction is dropped with no response.

## Timing
- Write: AWVALID&WVALID seen at edge t -> AWREADY/WREADY high in cycle t+1 (handshake at edge t+1, register updated) -> BVALID and wr_pulse_o high in cycle t+2.
- Read: ARVALID seen at edge t -> ARREADY high in cycle t+1 -> RVALID high in cycle t+2.
- Best-case back-to-back throughput is one transaction per 3 cycles per channel when BREADY/RREADY are held high.
- reg_o is registered and reflects a write from cycle t+2 onward.

## Configuration
- AXI_REGBANK_SLVERR_EN defined: out-of-range accesses return SLVERR (2'b10), and so do writes to RO registers. Read data for those accesses is still 0.
- AXI_REGBANK_SLVERR_EN undefined: every response is OKAY. Decoding and the no-state-change rules are unchanged.

## Structure
- Package axi_regbank_pkg: AXI resp constants (RESP_OKAY, RESP_SLVERR), write FSM enum (W_IDLE, W_RESP), read FSM enum (R_IDLE, R_DATA), and function word_index(addr, DATA_W).
- One sub-module, axi_regbank_strb_reg: one DATA_W register with byte-strobe write enable and async reset. It is instantiated NUM_REGS times in a generate loop, skipped for RO_MASK bits.

## Test plan
- Defaults: write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back -> each RDATA matches, RRESP = OKAY, and wr_pulse_o[i] pulses once per write.
- WSTRB = 4'b0010 with WDATA 0xAABBCCDD to reg 0, which holds 0x11223344 -> read returns 0x1122CC44.
- RO_MASK = 4'b0100, status_i slice 2 = 0xDEADBEEF; write 0x5 to 0x8 -> no change, no pulse; read 0x8 returns 0xDEADBEEF. With the macro, BRESP = SLVERR.
- Out-of-range read of 0x10 (NUM_REGS = 4) -> RDATA = 0; RRESP = SLVERR with the macro, OKAY without.
- BREADY/RREADY held low for 10 cycles -> BVALID/RVALID and RDATA stay stable, and no new AW/AR is accepted until the response completes.
- ARESETN asserted while BVALID is pending -> all outputs 0 in the same cycle; after release, a read of reg 0 returns 0 with no stale B.
